usart_cmd_ctrl: RTL and testbench
=================================

Name: usart_cmd_ctrl

Overview:
- Command sequencer for the logic analyzer's serial link. Sits between the USART receive/transmit pair and the capture core.
- Parses host command frames arriving as received bytes and executes them: arm, set sample divider, read status, read sample memory.
- Sends reply bytes and streams capture memory back through the transmit handshake.

Parameters:
ADDR_W, 16, sample memory address width (1..16); READ address is taken from the low ADDR_W bits of the 16-bit argument.
TIMEOUT, 1000000, clk cycles allowed between argument bytes before the frame is discarded.
DIV_RESET, 8'd1, reset value of div.

Ports:
clk  in  1  system clock.
nreset  in  1  asynchronous active-low reset.
rx_data  in  8  received byte; valid in the cycle rx_ready=1.
rx_ready  in  1  single-cycle pulse: new byte received.
rx_error  in  1  single-cycle pulse: framing error on the receiver.
tx_data  out  8  byte to transmit.
tx_write  out  1  transmit request; held with tx_data stable until accepted.
tx_fetch  in  1  single-cycle pulse: transmitter has taken tx_data.
tx_idle  in  1  transmitter idle.
mem_addr  out  ADDR_W  sample memory read address.
mem_rd  out  1  read strobe; mem_rdata is valid exactly 1 cycle after mem_rd=1.
mem_rdata  in  8  sample memory read data.
status_in  in  8  capture core status byte.
arm  out  1  single-cycle pulse: start capture.
div  out  8  sample clock divider register.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (nreset=0, asynchronous): state=IDLE; tx_data=0, tx_write=0, mem_addr=0, mem_rd=0, arm=0, busy=0, div=DIV_RESET; all counters 0.
- Frame: opcode byte, then argument bytes. 0x01 ARM (0 args), 0x02 STATUS (0 args), 0x03 READ (4 args: addr_hi, addr_lo, len_hi, len_lo), 0x04 SET_DIV (1 arg). Any other opcode: reply 0xEE, no other effect.
- States: IDLE -> ARGS (opcode needs args) or EXEC (no args) -> REPLY | MEM_RD -> MEM_WAIT -> STREAM -> MEM_RD ... -> IDLE.
- IDLE: on rx_ready, latch opcode; set the argument count from the opcode table.
- ARGS: each rx_ready stores the next argument and clears the timeout counter. Counter reaching TIMEOUT-1 with args outstanding -> IDLE, no reply, no side effects. rx_error in ARGS -> IDLE, frame discarded. rx_error in IDLE is ignored.
- EXEC (one cycle):
  - ARM: arm=1 for exactly this cycle; reply 0xAA.
  - SET_DIV: div<=arg0; reply 0xAA.
  - STATUS: reply status_in sampled in this cycle.
  - READ: addr<=arg[15:0] truncated to ADDR_W, remaining<=len[15:0]. If len=0 -> IDLE with nothing sent; otherwise -> MEM_RD.
- REPLY/STREAM tx handshake:
  - Raise tx_write with tx_data.
  - Hold both unchanged until the cycle tx_fetch=1.
  - tx_write=0 in the following cycle, for at least one cycle between bytes.
  - tx_fetch while tx_write=0 is ignored.
  - tx_idle is not required for acceptance.
- MEM_RD: mem_rd=1 for one cycle at mem_addr. MEM_WAIT: capture mem_rdata into tx_data. STREAM: handshake as above.
- On fetch in STREAM: remaining decrements and mem_addr increments modulo 2^ADDR_W (wrap from all-ones to 0). If remaining reaches 0 -> IDLE, else -> MEM_RD. Minimum per-byte controller overhead is 3 cycles plus the transmitter time.
- rx bytes and rx_error arriving in EXEC/REPLY/MEM_RD/MEM_WAIT/STREAM are dropped; no queueing.
- rx_ready and rx_error in the same cycle: the error wins and the byte is dropped.
- Reset asserted mid-stream: tx_write drops immediately (asynchronous) and the stream is abandoned.
- div changes only on SET_DIV execution or reset.

Test Plan:
- Reset, then rx 0x04,0x10 -> div=0x10 one cycle after the 2nd rx_ready; tx_write with tx_data=0xAA; hold tx_fetch low 50 cycles -> tx_write/tx_data stay constant; pulse tx_fetch -> tx_write=0 next cycle, busy=0.
- rx 0x01 -> arm high exactly one cycle; reply 0xAA; rx 0x02 with status_in=0x5C -> reply 0x5C.
- rx 0x03,0xFF,0xFE,0x00,0x04 with ADDR_W=16, mem[a]=a[7:0] -> mem_addr sequence FFFE,FFFF,0000,0001; tx bytes FE,FF,00,01; then IDLE.
- rx 0x03,0x00,0x10,0x00,0x00 (len=0) -> no tx_write, no mem_rd, busy low within 2 cycles.
- rx 0x04, then no byte for TIMEOUT cycles (TIMEOUT=100 in bench) -> IDLE, div unchanged, no tx. Separately, rx 0x03,0x00 then rx_error -> IDLE, no tx.
- rx 0x7F -> reply 0xEE. During a 4-byte READ stream, inject rx 0x01 -> arm stays 0 and the stream completes unchanged. Assert nreset mid-stream -> all outputs at reset values immediately, div=DIV_RESET.

Source files
------------

// File: rtl/usart_cmd_ctrl.sv
// Host command sequencer for the logic analyzer serial link: parses rx frames,
// executes ARM / STATUS / READ / SET_DIV and drives replies through the tx handshake.
module usart_cmd_ctrl #(
  parameter int          ADDR_W    = 16,
  parameter int          TIMEOUT   = 1000000,
  parameter logic [7:0]  DIV_RESET = 8'd1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  input  logic              rx_error,
  output logic [7:0]        tx_data,
  output logic              tx_write,
  input  logic              tx_fetch,
  input  logic              tx_idle,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic [7:0]        status_in,
  output logic              arm,
  output logic [7:0]        div,
  output logic              busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ARGS     = 3'd1;
  localparam logic [2:0] EXEC     = 3'd2;
  localparam logic [2:0] REPLY    = 3'd3;
  localparam logic [2:0] MEM_RD   = 3'd4;
  localparam logic [2:0] MEM_WAIT = 3'd5;
  localparam logic [2:0] STREAM   = 3'd6;

  localparam logic [7:0] OP_ARM    = 8'h01;
  localparam logic [7:0] OP_STATUS = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_DIV    = 8'h04;

  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic [7:0]       opcode;
  logic [7:0]       arg_q [0:3];
  logic [1:0]       arg_idx;
  logic [2:0]       arg_left;
  logic [TMO_W-1:0] tmo_cnt;
  logic [15:0]      remaining;
  logic [15:0]      addr_full;
  logic [15:0]      len_full;
  logic             rx_byte;

  // Acceptance relies solely on tx_fetch; tx_idle is informational only.
  logic unused_tx_idle;
  assign unused_tx_idle = tx_idle;

  // A framing error in the same cycle as a byte drops the byte.
  assign rx_byte   = rx_ready && !rx_error;
  assign addr_full = {arg_q[0], arg_q[1]};
  assign len_full  = {arg_q[2], arg_q[3]};

  assign busy   = (state != IDLE);
  assign mem_rd = (state == MEM_RD);
  assign arm    = (state == EXEC) && (opcode == OP_ARM);

  always_ff @(posedge clk) begin
    if (state == IDLE && rx_byte)
      opcode <= rx_data;
    if (state == ARGS && rx_byte)
      arg_q[arg_idx] <= rx_data;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state     <= IDLE;
      tx_data   <= 8'd0;
      tx_write  <= 1'b0;
      mem_addr  <= '0;
      div       <= DIV_RESET;
      arg_idx   <= 2'd0;
      arg_left  <= 3'd0;
      tmo_cnt   <= '0;
      remaining <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_byte) begin
            arg_idx <= 2'd0;
            tmo_cnt <= '0;
            case (rx_data)
              OP_READ: begin arg_left <= 3'd4; state <= ARGS; end
              OP_DIV:  begin arg_left <= 3'd1; state <= ARGS; end
              default: begin arg_left <= 3'd0; state <= EXEC; end
            endcase
          end
        end
        ARGS: begin
          if (rx_error) begin
            state <= IDLE;
          end else if (rx_ready) begin
            arg_idx  <= arg_idx + 2'd1;
            arg_left <= arg_left - 3'd1;
            tmo_cnt  <= '0;
            if (arg_left == 3'd1)
              state <= EXEC;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        EXEC: begin
          case (opcode)
            OP_ARM: begin
              tx_data <= 8'hAA; tx_write <= 1'b1; state <= REPLY;
            end
            OP_DIV: begin
              div <= arg_q[0];
              tx_data <= 8'hAA; tx_write <= 1'b1; state <= REPLY;
            end
            OP_STATUS: begin
              tx_data <= status_in; tx_write <= 1'b1; state <= REPLY;
            end
            OP_READ: begin
              mem_addr  <= addr_full[ADDR_W-1:0];
              remaining <= len_full;
              state     <= (len_full == 16'd0) ? IDLE : MEM_RD;
            end
            default: begin
              tx_data <= 8'hEE; tx_write <= 1'b1; state <= REPLY;
            end
          endcase
        end
        REPLY: begin
          if (tx_fetch) begin
            tx_write <= 1'b0;
            state    <= IDLE;
          end
        end
        MEM_RD: state <= MEM_WAIT;
        MEM_WAIT: begin
          tx_data  <= mem_rdata;
          tx_write <= 1'b1;
          state    <= STREAM;
        end
        STREAM: begin
          if (tx_fetch) begin
            tx_write  <= 1'b0;
            remaining <= remaining - 16'd1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            state     <= (remaining == 16'd1) ? IDLE : MEM_RD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usart_cmd_ctrl.sv
// Directed bench for usart_cmd_ctrl: command frames, tx handshake, memory streaming,
// timeout/error discard and asynchronous reset mid-stream.
module tb_usart_cmd_ctrl;

  logic        clk = 1'b0;
  logic        nreset;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_error;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic        tx_fetch;
  logic        tx_idle;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic [7:0]  status_in;
  logic        arm;
  logic [7:0]  div;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int arm_cnt = 0;
  int tx_cnt  = 0;
  logic tx_write_d = 1'b0;
  logic [15:0] addr_q [$];

  usart_cmd_ctrl #(.ADDR_W(16), .TIMEOUT(100), .DIV_RESET(8'd1)) dut (
    .clk(clk), .nreset(nreset),
    .rx_data(rx_data), .rx_ready(rx_ready), .rx_error(rx_error),
    .tx_data(tx_data), .tx_write(tx_write), .tx_fetch(tx_fetch), .tx_idle(tx_idle),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .status_in(status_in), .arm(arm), .div(div), .busy(busy)
  );

  always #5 clk = ~clk;

  // Sample memory: mem[a] = a[7:0], one cycle read latency.
  always @(posedge clk) if (mem_rd) mem_rdata <= mem_addr[7:0];

  always @(negedge clk) begin
    if (arm) arm_cnt <= arm_cnt + 1;
    if (mem_rd) addr_q.push_back(mem_addr);
    if (tx_write && !tx_write_d) tx_cnt <= tx_cnt + 1;
    tx_write_d <= tx_write;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic take(input string tag, output logic [7:0] b);
    int n = 0;
    while (!tx_write && n < 200) begin @(negedge clk); n++; end
    if (!tx_write) begin
      check({tag, "_timeout"}, 0, 1);
      b = 8'h00;
    end else begin
      b = tx_data;
      tx_fetch = 1'b1;
      @(negedge clk);
      tx_fetch = 1'b0;
      check({tag, "_drop"}, tx_write, 0);
    end
  endtask

  logic [7:0] b;
  int a0, t0;
  bit stable;

  initial begin
    nreset = 1'b0; rx_data = 8'h00; rx_ready = 1'b0; rx_error = 1'b0;
    tx_fetch = 1'b0; tx_idle = 1'b1; status_in = 8'h00;
    #12;
    check("rst_tx_write", tx_write, 0);
    check("rst_busy", busy, 0);
    check("rst_div", div, 8'h01);
    check("rst_outs", {tx_data, mem_addr, mem_rd, arm}, 0);
    @(negedge clk); nreset = 1'b1;

    // SET_DIV 0x10, then hold the reply unfetched
    send(8'h04); send(8'h10);
    check("div_not_yet", div, 8'h01);
    @(negedge clk);
    check("div_set", div, 8'h10);
    check("div_reply", {tx_write, tx_data}, {1'b1, 8'hAA});
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (!(tx_write && tx_data == 8'hAA)) stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    tx_fetch = 1'b1; @(negedge clk); tx_fetch = 1'b0;
    check("fetch_drop", tx_write, 0);
    check("fetch_idle", busy, 0);

    // ARM and STATUS
    a0 = arm_cnt;
    send(8'h01); take("arm", b);
    check("arm_reply", b, 8'hAA);
    check("arm_pulse", arm_cnt - a0, 1);
    status_in = 8'h5C;
    send(8'h02); take("status", b);
    check("status_reply", b, 8'h5C);

    // READ with address wrap
    addr_q.delete();
    send(8'h03); send(8'hFF); send(8'hFE); send(8'h00); send(8'h04);
    take("rd0", b); check("rd0_data", b, 8'hFE);
    take("rd1", b); check("rd1_data", b, 8'hFF);
    take("rd2", b); check("rd2_data", b, 8'h00);
    take("rd3", b); check("rd3_data", b, 8'h01);
    check("rd_idle", busy, 0);
    check("rd_nrd", addr_q.size(), 4);
    if (addr_q.size() == 4) begin
      check("rd_a0", addr_q[0], 16'hFFFE);
      check("rd_a1", addr_q[1], 16'hFFFF);
      check("rd_a2", addr_q[2], 16'h0000);
      check("rd_a3", addr_q[3], 16'h0001);
    end

    // READ with zero length
    addr_q.delete(); t0 = tx_cnt;
    send(8'h03); send(8'h00); send(8'h10); send(8'h00); send(8'h00);
    repeat (2) @(negedge clk);
    check("len0_idle", busy, 0);
    check("len0_notx", tx_cnt - t0, 0);
    check("len0_nord", addr_q.size(), 0);

    // Argument timeout
    t0 = tx_cnt;
    send(8'h04);
    repeat (50) @(negedge clk);
    check("tmo_still_busy", busy, 1);
    repeat (55) @(negedge clk);
    check("tmo_idle", busy, 0);
    check("tmo_div", div, 8'h10);
    check("tmo_notx", tx_cnt - t0, 0);

    // rx_error discards a partial frame
    send(8'h03); send(8'h00);
    @(negedge clk); rx_error = 1'b1; @(negedge clk); rx_error = 1'b0;
    check("err_idle", busy, 0);
    repeat (3) @(negedge clk);
    check("err_notx", tx_cnt - t0, 0);

    // Unknown opcode
    send(8'h7F); take("unk", b);
    check("unk_reply", b, 8'hEE);

    // rx_ready and rx_error together in IDLE: byte dropped
    a0 = arm_cnt;
    @(negedge clk); rx_data = 8'h01; rx_ready = 1'b1; rx_error = 1'b1;
    @(negedge clk); rx_ready = 1'b0; rx_error = 1'b0;
    @(negedge clk);
    check("both_idle", busy, 0);
    check("both_noarm", arm_cnt - a0, 0);

    // Byte injected during a stream is dropped
    a0 = arm_cnt;
    send(8'h03); send(8'h00); send(8'h20); send(8'h00); send(8'h04);
    take("inj0", b); check("inj0_data", b, 8'h20);
    send(8'h01);
    take("inj1", b); check("inj1_data", b, 8'h21);
    take("inj2", b); check("inj2_data", b, 8'h22);
    take("inj3", b); check("inj3_data", b, 8'h23);
    check("inj_noarm", arm_cnt - a0, 0);
    check("inj_idle", busy, 0);

    // Asynchronous reset mid-stream
    send(8'h03); send(8'h00); send(8'h40); send(8'h00); send(8'h04);
    take("mid0", b); check("mid0_data", b, 8'h40);
    begin
      int n = 0;
      while (!tx_write && n < 50) begin @(negedge clk); n++; end
    end
    check("mid_second_byte", {tx_write, tx_data}, {1'b1, 8'h41});
    #2 nreset = 1'b0;
    #1;
    check("mid_rst_tx_write", tx_write, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_div", div, 8'h01);
    check("mid_rst_outs", {tx_data, mem_addr, mem_rd, arm}, 0);
    @(negedge clk); nreset = 1'b1;
    t0 = tx_cnt;
    repeat (10) @(negedge clk);
    check("mid_abandoned", {busy, tx_write}, 0);
    check("mid_notx", tx_cnt - t0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
